// File: rtl/sub_bytes.sv
// AES SubBytes: forward S-box applied to all 16 bytes of a 128-bit state, one byte per clock.
// Latency: done_o rises 16 clocks after the start-accept edge; s_o is the working register.
// Backpressure: none; start_i is only honoured in IDLE, so requests made while BUSY are dropped.
module sub_bytes (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] s_i,
    input  logic         start_i,
    output logic [127:0] s_o,
    output logic         done_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state_q;
    logic [3:0]   idx_q;
    logic [127:0] work_q;
    logic         done_q;
    logic [7:0]   cur_byte;
    logic [7:0]   sub_d;

    // FIPS-197 forward S-box as a combinational ROM; one instance shared by all byte positions.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s;
        s = 8'h00;
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Select the byte addressed by the index and substitute it.
    always_comb begin
        cur_byte = work_q[{idx_q, 3'b000} +: 8];
        sub_d    = sbox(cur_byte);
    end

    // Control FSM and working register: load on accept, then rewrite one byte per clock, LSB byte first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            work_q  <= 128'h0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        work_q  <= s_i;
                        idx_q   <= 4'd0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    work_q[{idx_q, 3'b000} +: 8] <= sub_d;
                    if (idx_q == 4'd15) begin
                        idx_q   <= 4'd0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        idx_q  <= idx_q + 4'd1;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= 4'd0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_o    = work_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_sub_bytes.sv
// Bench for sub_bytes: randomized and directed starts, scoreboarded against a GF(2^8) reference.
// Reference S-box is derived from field inversion plus the affine map, not from a table.
// Monitor compares result and completion time whenever done_o is seen.
module tb_sub_bytes;

    logic         clk;
    logic         rst_n;
    logic [127:0] s_i;
    logic         start_i;
    logic [127:0] s_o;
    logic         done_o;

    typedef struct {
        logic [127:0] exp_s;
        int           exp_cyc;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_vec;
    int n_err;
    int cyc;
    logic prev_done;

    sub_bytes dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_i     (s_i),
        .start_i (start_i),
        .s_o     (s_o),
        .done_o  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box: multiplicative inverse (0 maps to 0) followed by the AES affine transform.
    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gf_mul(a, 8'(x)) == 8'h01) inv = 8'(x);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_sbox(v[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every done_o must match the oldest outstanding expectation in value and time.
    initial begin
        sb_entry_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done_o) begin
                if (prev_done) begin
                    n_err++;
                    $display("FAIL done_width: done_o high %0d consecutive cycles, required 1", 2);
                end
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: done_o at cycle %0d with nothing outstanding", cyc);
                end else begin
                    e = sb.pop_front();
                    n_vec++;
                    if (s_o !== e.exp_s) begin
                        n_err++;
                        $display("FAIL result: s_o=%h required %h", s_o, e.exp_s);
                    end
                    n_vec++;
                    if (cyc != e.exp_cyc) begin
                        n_err++;
                        $display("FAIL latency: done_o at cycle %0d required %0d", cyc, e.exp_cyc);
                    end
                end
            end
            prev_done = done_o;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Issue a one-cycle start and register the expected response.
    task automatic issue(input logic [127:0] v, input logic [127:0] exp_s);
        sb_entry_t e;
        @(negedge clk);
        s_i     = v;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        e.exp_s   = exp_s;
        e.exp_cyc = cyc + 16;
        sb.push_back(e);
        start_i = 1'b0;
    endtask

    // Bounded wait until every outstanding operation has been observed.
    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d operations outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_entry_t e;
        logic [127:0] a;
        logic [127:0] b;
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start_i = 1'b0;
        s_i     = 128'h0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            s_i     = rand128();
            start_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("reset_s_o", s_o, 128'h0);
            check("reset_done", {127'h0, done_o}, 128'h0);
        end
        start_i = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_s_o", s_o, 128'h0);
            check("post_reset_done", {127'h0, done_o}, 128'h0);
        end

        // Known vector, then result must hold while idle.
        issue(128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816);
        wait_drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_stable", s_o, 128'h638293c31bfc33f5c4eeacea4bc12816);
        end

        // Edge bytes.
        issue(128'h0, {16{8'h63}});
        wait_drain();
        issue({16{8'hff}}, {16{8'h16}});
        wait_drain();

        // Random vectors with random idle gaps.
        for (int i = 0; i < 8; i++) begin
            a = rand128();
            issue(a, ref_sub(a));
            wait_drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Start and s_i changes while busy are ignored.
        a = rand128();
        issue(a, ref_sub(a));
        repeat (4) @(posedge clk);
        #1;
        start_i = 1'b1;
        s_i     = rand128();
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_drain();
        repeat (20) @(negedge clk);

        // Reset mid-operation aborts immediately.
        a = rand128();
        issue(a, ref_sub(a));
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_s_o", s_o, 128'h0);
        check("abort_done", {127'h0, done_o}, 128'h0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a = rand128();
        issue(a, ref_sub(a));
        wait_drain();

        // Back-to-back with start held high.
        a = rand128();
        b = rand128();
        @(negedge clk);
        s_i     = a;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        e.exp_s   = ref_sub(a);
        e.exp_cyc = cyc + 16;
        sb.push_back(e);
        e.exp_s   = ref_sub(b);
        e.exp_cyc = cyc + 33;
        sb.push_back(e);
        s_i = b;
        repeat (17) @(posedge clk);
        #1;
        start_i = 1'b0;
        s_i     = rand128();
        wait_drain();
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
